alu_mc: RTL



---
 rtl/alu_mc.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU: registered single-cycle ops plus iterative MULTU/DIVU
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             ovf,
    output logic             err
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_SLL   = 4'b0100;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLTU  = 4'b1000;
    localparam logic [3:0] OP_SRA   = 4'b1001;
    localparam logic [3:0] OP_MULTU = 4'b1010;
    localparam logic [3:0] OP_DIVU  = 4'b1011;
    localparam logic [3:0] OP_NOR   = 4'b1100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic             accept;
    logic [SHW-1:0]   count;
    logic [WIDTH-1:0] work_hi;
    logic [WIDTH-1:0] work_lo;
    logic [WIDTH-1:0] operand_m;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sc_lo;
    logic [WIDTH-1:0] sc_hi;
    logic             sc_ovf;
    logic             sc_err;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_sub;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // DONE behaves like IDLE for acceptance so back-to-back ops stream one per cycle
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    if (op == OP_MULTU) begin
                        next_state = S_MUL;
                    end else if (op == OP_DIVU && b != '0) begin
                        next_state = S_DIV;
                    end else begin
                        next_state = S_DONE;
                    end
                end else begin
                    next_state = S_IDLE;
                end
            end
            S_MUL, S_DIV: begin
                if (count == '0) begin
                    next_state = S_DONE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE:  in_ready = 1'b1;
            S_DONE: begin
                in_ready  = 1'b1;
                out_valid = 1'b1;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    assign sum   = a + b;
    assign diff  = a - b;
    assign shamt = b[SHW-1:0];

    always_comb begin
        sc_lo  = '0;
        sc_hi  = '0;
        sc_ovf = 1'b0;
        sc_err = 1'b0;
        case (op)
            OP_AND:  sc_lo = a & b;
            OP_OR:   sc_lo = a | b;
            OP_XOR:  sc_lo = a ^ b;
            OP_NOR:  sc_lo = ~(a | b);
            OP_ADD: begin
                sc_lo  = sum;
                sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_lo  = diff;
                sc_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT:  sc_lo = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: sc_lo = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL:  sc_lo = a << shamt;
            OP_SRL:  sc_lo = a >> shamt;
            OP_SRA:  sc_lo = $signed(a) >>> shamt;
            OP_MULTU: sc_lo = '0;
            OP_DIVU: begin
                // only reaches the result registers when b == 0
                sc_lo  = '1;
                sc_hi  = a;
                sc_err = 1'b1;
            end
            default: sc_err = 1'b1;
        endcase
    end

    // Shift-add multiply: {work_hi, work_lo} shifts right, work_lo holds the remaining multiplier bits
    assign mul_sum = {1'b0, work_hi} + (work_lo[0] ? {1'b0, operand_m} : '0);

    // Restoring divide: work_hi is the partial remainder, work_lo shifts dividend out and quotient in
    assign div_shift = {work_hi, work_lo[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, operand_m};
    assign div_sub   = div_shift[WIDTH-1:0] - operand_m;

    always_comb begin
        step_hi = '0;
        step_lo = '0;
        if (state == S_MUL) begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], work_lo[WIDTH-1:1]};
        end else begin
            step_hi = div_ge ? div_sub : div_shift[WIDTH-1:0];
            step_lo = {work_lo[WIDTH-2:0], div_ge};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            work_hi   <= '0;
            work_lo   <= '0;
            operand_m <= '0;
            result_lo <= '0;
            result_hi <= '0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
            err       <= 1'b0;
        end else if (accept) begin
            work_hi   <= '0;
            work_lo   <= a;
            operand_m <= b;
            count     <= CNT_LAST;
            if (next_state == S_DONE) begin
                result_lo <= sc_lo;
                result_hi <= sc_hi;
                zero      <= (sc_lo == '0);
                ovf       <= sc_ovf;
                err       <= sc_err;
            end
        end else if (state == S_MUL || state == S_DIV) begin
            work_hi <= step_hi;
            work_lo <= step_lo;
            if (count == '0) begin
                result_lo <= step_lo;
                result_hi <= step_hi;
                zero      <= (step_lo == '0);
                ovf       <= 1'b0;
                err       <= 1'b0;
            end else begin
                count <= count - SHW'(1);
            end
        end
    end

endmodule
